// File: rtl/ama_riscv_csr_pkg.sv
// CSR address map, op encodings and read-modify-write helper
// shared by the ama_riscv CSR responder and its counters.
package ama_riscv_csr_pkg;

  localparam logic [11:0] CSR_TOHOST    = 12'h51E;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [11:0] CSR_RO_MASK   = 12'hC00;

  localparam logic [1:0] CSR_OP_ILL = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  function automatic logic [31:0] csr_alu(
    input logic [1:0]  op,
    input logic [31:0] old,
    input logic [31:0] src
  );
    logic [31:0] res;
    res = src;
    unique case (op)
      CSR_OP_RS: res = old | src;
      CSR_OP_RC: res = old & ~src;
      default:   res = src;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ama_riscv_csr_counter64.sv
// 64-bit CSR counter with per-half write that
// pre-empts the increment (and carry) in that cycle.
module ama_riscv_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  logic [63:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (we_lo) begin
      r_cnt[31:0] <= wdata;
    end else if (we_hi) begin
      r_cnt[63:32] <= wdata;
    end else if (inc) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/ama_riscv_csr.sv
// EX-stage CSR responder with tohost; counters are built in
// when AMA_RISCV_CSR_COUNTERS_EN is defined.
module ama_riscv_csr
  import ama_riscv_csr_pkg::*;
#(
  parameter logic [11:0] CSR_TOHOST_ADDR = CSR_TOHOST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic        csr_we,
  input  logic        csr_ui,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_uimm,
  input  logic [31:0] rs1_data,
  input  logic        csr_kill,
  input  logic        inst_retired,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] tohost,
  output logic        tohost_valid
);

  logic        w_acc;
  logic        w_wr_req;
  logic        w_hit;
  logic        w_ro;
  logic        w_illegal;
  logic        w_wr;
  logic        w_sel_tohost;
  logic [31:0] w_src;
  logic [31:0] w_old;
  logic [31:0] w_new;

  logic [31:0] r_rdata;
  logic        r_illegal;
  logic [31:0] r_tohost;
  logic        r_tohost_valid;

`ifdef AMA_RISCV_CSR_COUNTERS_EN
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
`else
  logic        w_unused;
  assign w_unused = inst_retired;
`endif

  assign w_acc = csr_en & ~csr_kill;
  assign w_src = csr_ui ? {27'b0, csr_uimm} : rs1_data;
  assign w_ro  = (csr_addr & CSR_RO_MASK) == CSR_RO_MASK;

  // set/clear with a zero source is a pure read
  assign w_wr_req = csr_we &
    ~((csr_op != CSR_OP_RW) & (csr_uimm == 5'd0));

  always_comb begin
    w_hit        = 1'b0;
    w_old        = '0;
    w_sel_tohost = 1'b0;
    unique case (1'b1)
      (csr_addr == CSR_TOHOST_ADDR): begin
        w_hit        = 1'b1;
        w_old        = r_tohost;
        w_sel_tohost = 1'b1;
      end
`ifdef AMA_RISCV_CSR_COUNTERS_EN
      (csr_addr == CSR_MCYCLE),
      (csr_addr == CSR_CYCLE): begin
        w_hit = 1'b1;
        w_old = w_mcycle[31:0];
      end
      (csr_addr == CSR_MCYCLEH),
      (csr_addr == CSR_CYCLEH): begin
        w_hit = 1'b1;
        w_old = w_mcycle[63:32];
      end
      (csr_addr == CSR_MINSTRET),
      (csr_addr == CSR_INSTRET): begin
        w_hit = 1'b1;
        w_old = w_minstret[31:0];
      end
      (csr_addr == CSR_MINSTRETH),
      (csr_addr == CSR_INSTRETH): begin
        w_hit = 1'b1;
        w_old = w_minstret[63:32];
      end
`endif
      default: ;
    endcase
  end

  assign w_illegal = w_acc & (~w_hit |
    (csr_op == CSR_OP_ILL) | (w_ro & w_wr_req));
  assign w_wr  = w_acc & w_wr_req & ~w_illegal;
  assign w_new = csr_alu(csr_op, w_old, w_src);

`ifdef AMA_RISCV_CSR_COUNTERS_EN
  ama_riscv_csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (w_wr & (csr_addr == CSR_MCYCLE)),
    .we_hi (w_wr & (csr_addr == CSR_MCYCLEH)),
    .wdata (w_new),
    .cnt   (w_mcycle)
  );

  ama_riscv_csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retired),
    .we_lo (w_wr & (csr_addr == CSR_MINSTRET)),
    .we_hi (w_wr & (csr_addr == CSR_MINSTRETH)),
    .wdata (w_new),
    .cnt   (w_minstret)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata        <= '0;
      r_illegal      <= 1'b0;
      r_tohost       <= '0;
      r_tohost_valid <= 1'b0;
    end else begin
      r_rdata        <= (w_acc & ~w_illegal) ? w_old : '0;
      r_illegal      <= w_illegal;
      r_tohost_valid <= w_wr & w_sel_tohost;
      if (w_wr & w_sel_tohost) r_tohost <= w_new;
    end
  end

  assign csr_rdata    = r_rdata;
  assign csr_illegal  = r_illegal;
  assign tohost       = r_tohost;
  assign tohost_valid = r_tohost_valid;

endmodule

// File: tb/tb_ama_riscv_csr.sv
// Directed scoreboard bench for ama_riscv_csr; counter
// checks follow AMA_RISCV_CSR_COUNTERS_EN.
module tb_ama_riscv_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en, csr_we, csr_ui, csr_kill, inst_retired;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [4:0]  csr_uimm;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata, tohost;
  logic        csr_illegal, tohost_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        ill;
  } exp_t;

  exp_t q[$];

  ama_riscv_csr dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .csr_we       (csr_we),
    .csr_ui       (csr_ui),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_uimm     (csr_uimm),
    .rs1_data     (rs1_data),
    .csr_kill     (csr_kill),
    .inst_retired (inst_retired),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic        en,
    input logic        we,
    input logic        ui,
    input logic [1:0]  op,
    input logic [11:0] addr,
    input logic [4:0]  uimm,
    input logic [31:0] rs1,
    input logic        kill,
    input logic        ret,
    input logic [31:0] exp_rd,
    input logic        exp_ill
  );
    exp_t e;
    csr_en       = en;
    csr_we       = we;
    csr_ui       = ui;
    csr_op       = op;
    csr_addr     = addr;
    csr_uimm     = uimm;
    rs1_data     = rs1;
    csr_kill     = kill;
    inst_retired = ret;
    q.push_back('{tag, exp_rd, exp_ill});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".rd"}, csr_rdata, e.rd);
      chk({e.tag, ".ill"}, {31'b0, csr_illegal}, {31'b0, e.ill});
    end
  endtask

  task automatic idle(input string tag, input logic ret);
    step(tag, 0, 0, 0, 2'b00, 12'h000, 5'd0, 32'h0, 0, ret,
         32'h0, 1'b0);
  endtask

  task automatic chk_th(input string tag,
                        input logic [31:0] th,
                        input logic vld);
    chk({tag, ".tohost"}, tohost, th);
    chk({tag, ".valid"}, {31'b0, tohost_valid}, {31'b0, vld});
  endtask

  initial begin
    rst = 1'b1;
    idle("rst0", 0);
    idle("rst1", 0);
    chk_th("rst", 32'h0, 0);
    rst = 1'b0;

    step("rw1", 1, 1, 0, 2'b01, 12'h51E, 5'd1, 32'h1, 0, 0,
         32'h0, 0);
    chk_th("rw1", 32'h1, 1);
    idle("idle1", 0);
    chk_th("idle1", 32'h1, 0);

    step("rwF0", 1, 1, 0, 2'b01, 12'h51E, 5'd2, 32'hF0, 0, 0,
         32'h1, 0);
    chk_th("rwF0", 32'hF0, 1);
    step("rsi", 1, 1, 1, 2'b10, 12'h51E, 5'h0F, 32'h0, 0, 0,
         32'hF0, 0);
    chk_th("rsi", 32'hFF, 1);
    step("rc0", 1, 1, 0, 2'b11, 12'h51E, 5'd0, 32'hFFFF_FFFF,
         0, 0, 32'hFF, 0);
    chk_th("rc0", 32'hFF, 0);
    step("rci", 1, 1, 1, 2'b11, 12'h51E, 5'h03, 32'h0, 0, 0,
         32'hFF, 0);
    chk_th("rci", 32'hFC, 1);

    step("kill", 1, 1, 0, 2'b01, 12'h51E, 5'd1, 32'hDEAD, 1, 0,
         32'h0, 0);
    chk_th("kill", 32'hFC, 0);
    step("unmap", 1, 1, 0, 2'b01, 12'h7C0, 5'd1, 32'h5, 0, 0,
         32'h0, 1);
    chk_th("unmap", 32'hFC, 0);
    idle("idle2", 0);

    step("b2b_a", 1, 1, 0, 2'b01, 12'h51E, 5'd1, 32'hA, 0, 0,
         32'hFC, 0);
    chk_th("b2b_a", 32'hA, 1);
    step("b2b_b", 1, 1, 0, 2'b01, 12'h51E, 5'd1, 32'hB, 0, 0,
         32'hA, 0);
    chk_th("b2b_b", 32'hB, 1);
    step("op00", 1, 1, 0, 2'b00, 12'h51E, 5'd1, 32'h9, 0, 0,
         32'h0, 1);
    chk_th("op00", 32'hB, 0);
    step("rs_x0", 1, 1, 0, 2'b10, 12'h51E, 5'd0, 32'hFF00,
         0, 0, 32'hB, 0);
    chk_th("rs_x0", 32'hB, 0);

`ifndef AMA_RISCV_CSR_COUNTERS_EN
    step("noc_b00", 1, 0, 0, 2'b10, 12'hB00, 5'd0, 32'h0, 0, 0,
         32'h0, 1);
    step("noc_c00", 1, 0, 0, 2'b10, 12'hC00, 5'd0, 32'h0, 0, 1,
         32'h0, 1);
`endif

    rst = 1'b1;
    step("rst_mid", 1, 1, 0, 2'b01, 12'h51E, 5'd1, 32'h77, 0, 1,
         32'h0, 0);
    chk_th("rst_mid", 32'h0, 0);
    rst = 1'b0;

`ifdef AMA_RISCV_CSR_COUNTERS_EN
    step("mc_w100", 1, 1, 0, 2'b01, 12'hB00, 5'd1, 32'd100,
         0, 0, 32'h0, 0);
    step("mc_wmax", 1, 1, 0, 2'b01, 12'hB00, 5'd1,
         32'hFFFF_FFFF, 0, 0, 32'd100, 0);
    step("cyc_rd", 1, 0, 0, 2'b10, 12'hC00, 5'd0, 32'h0, 0, 0,
         32'hFFFF_FFFF, 0);
    step("cych_rd", 1, 0, 0, 2'b10, 12'hC80, 5'd0, 32'h0, 0, 0,
         32'h1, 0);
    step("mc_rd", 1, 0, 0, 2'b10, 12'hB00, 5'd0, 32'h0, 0, 0,
         32'h1, 0);
    step("cyc_wr", 1, 1, 0, 2'b01, 12'hC00, 5'd1, 32'h3, 0, 0,
         32'h0, 1);
    step("mch_w", 1, 1, 0, 2'b01, 12'hB80, 5'd1, 32'h7, 0, 0,
         32'h1, 0);
    step("mch_rd", 1, 0, 0, 2'b10, 12'hB80, 5'd0, 32'h0, 0, 0,
         32'h7, 0);
    step("mi_rd0", 1, 0, 0, 2'b10, 12'hB02, 5'd0, 32'h0, 0, 0,
         32'h0, 0);
    for (int i = 0; i < 10; i++) idle("ret", 1);
    step("mi_rd10", 1, 0, 0, 2'b10, 12'hB02, 5'd0, 32'h0, 0, 0,
         32'd10, 0);
    step("mi_w5", 1, 1, 0, 2'b01, 12'hB02, 5'd1, 32'd5, 0, 1,
         32'd10, 0);
    step("mi_rd5", 1, 0, 0, 2'b10, 12'hB02, 5'd0, 32'h0, 0, 0,
         32'd5, 0);
    step("ir_rd5", 1, 0, 0, 2'b10, 12'hC02, 5'd0, 32'h0, 0, 0,
         32'd5, 0);
    step("irh_rd", 1, 0, 0, 2'b10, 12'hC82, 5'd0, 32'h0, 0, 0,
         32'd0, 0);
`endif

    idle("tail", 0);
    chk_th("tail", 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
